// File: rtl/md_hilo_unit.sv
// md_hilo_unit: issues mul/div ops to div_mlt, waits a fixed latency, commits results to HI/LO.
module md_hilo_unit #(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_dz,
  output logic        o_md_en,
  output logic        o_md_mul,
  output logic        o_md_sign,
  output logic [31:0] o_md_A,
  output logic [31:0] o_md_B,
  input  logic [31:0] i_md_hi,
  input  logic [31:0] i_md_lo
);
  localparam int MAXL = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAXL + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic dz_q, dz_d, mul_q, mul_d, sign_q, sign_d;
  logic accept, div_zero;
  always_comb begin
    accept = state_q == IDLE && i_op_valid && !i_flush;
    div_zero = i_op[2:1] == 2'b01 && i_rt == 32'd0;
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    mul_d = mul_q;
    sign_d = sign_q;
    dz_d = accept && div_zero;
    if (i_flush) state_d = IDLE;
    else if (accept && !i_op[2] && !div_zero) begin
      a_d = i_rs;
      b_d = i_rt;
      mul_d = !i_op[1];
      sign_d = !i_op[0];
      cnt_d = i_op[1] ? CW'(DIV_LAT) : CW'(MUL_LAT);
      state_d = ISSUE;
    end
    else if (state_q == ISSUE) state_d = WAIT;
    else if (state_q == WAIT) begin
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? COMMIT : WAIT;
    end
    else if (state_q == COMMIT) begin
      hi_d = i_md_hi;
      lo_d = i_md_lo;
      state_d = IDLE;
    end
    // MTHI/MTLO write straight through at the accepting edge
    if (accept && i_op == 3'b100) hi_d = i_rs;
    if (accept && i_op == 3'b101) lo_d = i_rs;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      b_q <= '0;
      dz_q <= 1'b0;
      mul_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      dz_q <= dz_d;
      mul_q <= mul_d;
      sign_q <= sign_d;
    end
  end
  assign o_busy = state_q != IDLE;
  assign o_md_en = state_q == ISSUE && !i_flush;
  assign o_hi = hi_q;
  assign o_lo = lo_q;
  assign o_dz = dz_q;
  assign o_md_mul = mul_q;
  assign o_md_sign = sign_q;
  assign o_md_A = a_q;
  assign o_md_B = b_q;
endmodule
